// File: rtl/rr_grant_encoder_if.sv
// Grant-offer bundle between the round-robin encoder and its consumer.
// master = encoder side (drives the offer), slave = requester/consumer side.
interface rr_grant_encoder_if #(
  parameter int WIDTH = 4,
  parameter int IDX_W = 2
);
  logic [WIDTH-1:0] req;
  logic             ack;
  logic             load;
  logic [WIDTH-1:0] grant;
  logic [IDX_W-1:0] grant_id;
  logic             busy;

  modport master (input req, ack, output load, grant, grant_id, busy);
  modport slave  (output req, ack, input load, grant, grant_id, busy);
endinterface

// File: rtl/rr_grant_encoder.sv
// Round-robin request encoder: picks one requester starting at a rotating
// pointer, offers it (load until ack), holds it until the winner drops its
// request, then moves priority to the requester just past the winner.
module rr_grant_encoder #(
  parameter int WIDTH = 4,
  parameter int IDX_W = 2
) (
  input logic                 clock,
  input logic                 reset,
  rr_grant_encoder_if.master  bus
);

  typedef enum logic [1:0] {IDLE, OFFER, HOLD} state_t;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] win;
  logic [WIDTH-1:0] win_oh;
  logic             found;
  logic [IDX_W-1:0] next_ptr;

  // Index p+k modulo WIDTH; WIDTH need not be a power of two, so wrap explicitly.
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= WIDTH) s = s - WIDTH;
    return IDX_W'(s);
  endfunction

  // First set request bit in the order ptr, ptr+1, ..., wrapping to ptr-1.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < WIDTH; k++) begin
      if (!found && bus.req[wrap_add(ptr, k)]) begin
        found = 1'b1;
        win   = wrap_add(ptr, k);
      end
    end
  end

  // One-hot form of the winner, loaded straight into the grant register.
  always_comb begin
    win_oh      = '0;
    win_oh[win] = 1'b1;
  end

  // Priority moves one past the released winner, wrapping at WIDTH-1.
  assign next_ptr = wrap_add(bus.grant_id, 1);

  // Offer/hold state machine; all outputs are registered here.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      ptr          <= '0;
      bus.load     <= 1'b0;
      bus.grant    <= '0;
      bus.grant_id <= '0;
      bus.busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|bus.req) begin
            bus.grant    <= win_oh;
            bus.grant_id <= win;
            bus.load     <= 1'b1;
            bus.busy     <= 1'b1;
            state        <= OFFER;
          end
        end
        OFFER: begin
          if (bus.ack) begin
            // Acceptance wins over a same-cycle withdrawal; HOLD then releases.
            bus.load <= 1'b0;
            state    <= HOLD;
          end else if (!bus.req[bus.grant_id]) begin
            // Withdrawn before acceptance: drop the offer, keep priority.
            bus.load     <= 1'b0;
            bus.grant    <= '0;
            bus.grant_id <= '0;
            bus.busy     <= 1'b0;
            state        <= IDLE;
          end
        end
        HOLD: begin
          if (!bus.req[bus.grant_id]) begin
            bus.grant    <= '0;
            bus.grant_id <= '0;
            bus.busy     <= 1'b0;
            ptr          <= next_ptr;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_grant_encoder.sv
// Directed bench for rr_grant_encoder (WIDTH=4) with hand-computed expectations.
module tb_rr_grant_encoder;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  rr_grant_encoder_if #(.WIDTH(4), .IDX_W(2)) bus ();

  rr_grant_encoder #(.WIDTH(4), .IDX_W(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic l, input logic [3:0] g,
                         input logic [1:0] id, input logic b);
    chk({tag, ".load"},     32'(bus.load),     32'(l));
    chk({tag, ".grant"},    32'(bus.grant),    32'(g));
    chk({tag, ".grant_id"}, 32'(bus.grant_id), 32'(id));
    chk({tag, ".busy"},     32'(bus.busy),     32'(b));
  endtask

  // Advance one rising edge and settle 1ns past it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [1:0] fair_exp [5];
    fair_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    checks  = 0;
    errors  = 0;
    reset   = 1'b0;
    bus.req = '0;
    bus.ack = 1'b0;

    // Reset held for three edges.
    repeat (3) step();
    chk_out("reset", 1'b0, 4'b0000, 2'd0, 1'b0);
    reset = 1'b1;

    // Single request: one-cycle latency, ack, release.
    bus.req = 4'b0100;
    step();
    chk_out("single.offer", 1'b1, 4'b0100, 2'd2, 1'b1);
    step();
    chk_out("single.wait", 1'b1, 4'b0100, 2'd2, 1'b1);
    bus.ack = 1'b1;
    step();
    chk_out("single.ack", 1'b0, 4'b0100, 2'd2, 1'b1);
    bus.ack = 1'b0;
    step();
    chk_out("single.hold", 1'b0, 4'b0100, 2'd2, 1'b1);
    bus.req = 4'b0000;
    step();
    chk_out("single.release", 1'b0, 4'b0000, 2'd0, 1'b0);

    // Wrap and skip: ptr=3, requesters 0 and 1 -> 0 wins.
    bus.req = 4'b0011;
    step();
    chk_out("wrap.offer", 1'b1, 4'b0001, 2'd0, 1'b1);
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
    bus.req = 4'b0010;
    step();
    chk_out("wrap.release", 1'b0, 4'b0000, 2'd0, 1'b0);
    bus.req = 4'b0011;
    step();
    chk_out("wrap.next", 1'b1, 4'b0010, 2'd1, 1'b1);

    // Withdrawal before ack: drop offer, ptr stays at 1.
    bus.req = 4'b0000;
    step();
    chk_out("withdraw", 1'b0, 4'b0000, 2'd0, 1'b0);
    step();
    chk_out("withdraw.idle", 1'b0, 4'b0000, 2'd0, 1'b0);
    bus.req = 4'b0011;
    step();
    chk_out("withdraw.regrant", 1'b1, 4'b0010, 2'd1, 1'b1);

    // Simultaneous ack and withdrawal: HOLD for one cycle, then release.
    bus.ack = 1'b1;
    bus.req = 4'b0001;
    step();
    chk_out("simul.hold", 1'b0, 4'b0010, 2'd1, 1'b1);
    bus.ack = 1'b0;
    bus.req = 4'b0000;
    step();
    chk_out("simul.release", 1'b0, 4'b0000, 2'd0, 1'b0);
    // ptr now 2: search 2,3,0 -> requester 0 (would be 1 if ptr had not moved).
    bus.req = 4'b0011;
    step();
    chk_out("simul.ptr", 1'b1, 4'b0001, 2'd0, 1'b1);
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
    bus.req = 4'b0000;
    step();
    chk_out("simul.idle", 1'b0, 4'b0000, 2'd0, 1'b0);

    // Async reset mid-HOLD with grant=1000 (ptr=1 here).
    bus.req = 4'b1000;
    step();
    chk_out("areset.offer", 1'b1, 4'b1000, 2'd3, 1'b1);
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
    chk_out("areset.hold", 1'b0, 4'b1000, 2'd3, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk_out("areset.immediate", 1'b0, 4'b0000, 2'd0, 1'b0);
    bus.req = 4'b1001;
    reset   = 1'b1;
    step();
    chk_out("areset.after", 1'b1, 4'b0001, 2'd0, 1'b1);

    // Fairness from a clean ptr=0 with all four requesting.
    #2 reset = 1'b0;
    #1 reset = 1'b1;
    bus.req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("fair%0d.id", i),   32'(bus.grant_id), 32'(fair_exp[i]));
      chk($sformatf("fair%0d.load", i), 32'(bus.load),     32'd1);
      bus.ack = 1'b1;
      step();
      bus.ack = 1'b0;
      bus.req = 4'b1111 & ~(4'b0001 << fair_exp[i]);
      step();
      chk($sformatf("fair%0d.gap", i),  32'(bus.busy),     32'd0);
      bus.req = 4'b1111;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
